// File: rtl/seq_mult.sv
// Sequential unsigned shift-and-add multiplier.
// One w-bit ripple adder is shared across all iterations: each RUN cycle adds
// the multiplicand into the accumulator when the current multiplier LSB is set,
// then shifts {C,A,Q} right by one. After w iterations {A,Q} holds a*b.

// ---------------------------------------------------------------------------
// w-bit ripple-carry adder built from a chain of full adders.
// ---------------------------------------------------------------------------
module adder #(
    parameter int w = 8
) (
    input  logic [w-1:0] a_i,
    input  logic [w-1:0] b_i,
    input  logic         ci_i,
    output logic [w-1:0] sum_o,
    output logic         co_o,
    output logic         ovf_o
);

    // carry[k] is the carry into bit k; carry[w] is the final carry-out.
    logic [w:0] carry;

    assign carry[0] = ci_i;

    genvar gi;
    generate
        for (gi = 0; gi < w; gi = gi + 1) begin : g_fa
            // One full-adder cell of the ripple chain.
            assign sum_o[gi]   = a_i[gi] ^ b_i[gi] ^ carry[gi];
            assign carry[gi+1] = (a_i[gi] & b_i[gi])
                               | (a_i[gi] & carry[gi])
                               | (b_i[gi] & carry[gi]);
        end
    endgenerate

    assign co_o  = carry[w];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_o = carry[w] ^ carry[w-1];

endmodule

// ---------------------------------------------------------------------------
// Multiplier controller and datapath.
// ---------------------------------------------------------------------------
module seq_mult #(
    parameter int w = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [w-1:0]   a,
    input  logic [w-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*w-1:0] product
);

    localparam int CW = $clog2(w) + 1;
    // Value of count on the final (w-th) RUN edge.
    localparam logic [CW-1:0] LAST_COUNT = CW'(w - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [w-1:0]   m_q;        // multiplicand
    logic [w-1:0]   a_q;        // accumulator (high half of partial product)
    logic [w-1:0]   q_q;        // multiplier, shifted out as low product fills in
    logic           c_q;        // carry above the accumulator
    logic [CW-1:0]  count_q;    // iterations completed
    logic           busy_q;
    logic           done_q;
    logic [2*w-1:0] product_q;

    logic [w-1:0]   a_d;
    logic [w-1:0]   q_d;
    logic           c_d;
    logic [CW-1:0]  count_d;

    // Adder result for this iteration.
    logic [w-1:0]   add_sum;
    logic           add_co;
    logic           adder_ovf_unused;

    // {carry, accumulator} selected before the shift.
    logic [w:0]     step_sum;

    adder #(
        .w (w)
    ) u_adder (
        .a_i   (a_q),
        .b_i   (m_q),
        .ci_i  (1'b0),
        .sum_o (add_sum),
        .co_o  (add_co),
        .ovf_o (adder_ovf_unused)
    );

    // Next datapath values for one RUN iteration: conditional add, then a
    // one-bit right shift of {C,A,Q}. C is always zero after a shift, so
    // feeding it back on the no-add path matches the plain {0,A} choice.
    always_comb begin
        step_sum = {c_q, a_q};
        if (q_q[0]) begin
            step_sum = {add_co, add_sum};
        end
        a_d     = step_sum[w:1];
        q_d     = {step_sum[0], q_q[w-1:1]};
        c_d     = 1'b0;
        count_d = count_q + CW'(1);
    end

    // Control FSM with registered handshake and product outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new start exactly like IDLE, giving
                // back-to-back operation with no idle cycle in between.
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        m_q     <= a;
                        q_q     <= b;
                        a_q     <= '0;
                        c_q     <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                // start is ignored here; operands were captured at launch.
                ST_RUN: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    c_q     <= c_d;
                    count_q <= count_d;
                    if (count_q == LAST_COUNT) begin
                        product_q <= {a_d, q_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: directed operations, an abstract timing/value model and
// a per-cycle compare of busy/done/product, plus literal expected products.
module tb_seq_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    bit chk_en = 0;

    seq_mult #(.w(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: a multiply is a*b, ready W edges after launch
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pending = '0;
    int             m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_pending;
                end
            end else if (start) begin
                m_busy    <= 1'b1;
                m_left    <= W;
                m_pending <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("product", 64'(product), 64'(m_prod));
        end
        if (done === 1'b1) n_done++;
    end

    // Drive a start pulse with the given operands at the next falling edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
    endtask

    // Wait (bounded) for done; cyc counts falling edges since launch.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done within %0d cycles", 3 * W);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] exp);
        int cyc;
        int d0;
        launch(av, bv);
        d0 = n_done;
        wait_done(cyc);
        check({name, "_latency"}, 64'(cyc), 64'(W + 1));
        check({name, "_product"}, 64'(product), 64'(exp));
        check({name, "_model"}, 64'(m_prod), 64'(exp));
        repeat (3) @(negedge clk);
        check({name, "_hold"}, 64'(product), 64'(exp));
        check({name, "_ndone"}, 64'(n_done - d0), 64'd1);
    endtask

    initial begin
        int cyc;
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_op("mul13x11", 8'd13, 8'd11, 16'd143);
        run_op("mul255x255", 8'd255, 8'd255, 16'hFE01);
        run_op("mul0x200", 8'd0, 8'd200, 16'd0);
        run_op("mul200x0", 8'd200, 8'd0, 16'd0);
        run_op("mul1x1", 8'd1, 8'd1, 16'd1);
        run_op("mul128x2", 8'd128, 8'd2, 16'd256);

        // start during RUN must be ignored
        launch(8'd7, 8'd9);
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        start = 1'b1;
        a = 8'd100;
        b = 8'd100;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        for (int i = 0; i < 3 * W && done !== 1'b1; i++) begin
            @(negedge clk);
            cyc++;
        end
        check("ignored_start_latency", 64'(cyc), 64'(W + 1));
        check("ignored_start_product", 64'(product), 64'd63);
        repeat (2) @(negedge clk);

        // reset in the middle of an operation discards it
        launch(8'd50, 8'd50);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        d0 = n_done;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", 64'(product), 64'd0);
        repeat (2 * W) @(negedge clk);
        check("midrst_nodone", 64'(n_done - d0), 64'd0);
        check("midrst_product_after", 64'(product), 64'd0);

        // back-to-back: new start accepted during the done cycle
        launch(8'd3, 8'd5);
        wait_done(cyc);
        check("b2b_first_product", 64'(product), 64'd15);
        start = 1'b1;
        a = 8'd6;
        b = 8'd7;
        wait_done(cyc);
        check("b2b_second_latency", 64'(cyc), 64'(W + 1));
        check("b2b_second_product", 64'(product), 64'd42);
        check("b2b_second_model", 64'(m_prod), 64'd42);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
